// File: rtl/decoder_nx_seq.sv
// decoder_nx_seq: registered 1-of-2^SEL_W decoder with enable.
// Modes: DECODE (continuous decode of sel), PULSE (one output cycle per
// sampled load), SCAN (walking one with a programmable dwell per output).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | outputs off: after reset, en low, mode 11, or SCAN not running
// ST_DECODE| mode 00: d follows sel one cycle later
// ST_PULSE | mode 01: d shows sel for the cycle after each sampled load
// ST_SCAN  | mode 10 with a scan in progress; idx walks, dwell_cnt counts
module decoder_nx_seq #(
  parameter int SEL_W     = 2,
  parameter int DWELL     = 1,
  parameter bit SCAN_WRAP = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  load,
  output logic [2**SEL_W-1:0]   d,
  output logic [SEL_W-1:0]      idx,
  output logic                  active,
  output logic                  scan_done
);

  localparam int OUTS  = 2**SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = '1;

  localparam logic [1:0] MODE_DECODE = 2'b00;
  localparam logic [1:0] MODE_PULSE  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_PULSE,
    ST_SCAN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;

  function automatic logic [OUTS-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Single FSM: every output is registered here, so active tracks d exactly
  // and d is never more than one-hot. The scan step uses a rotate, which also
  // covers the OUTS-1 -> 0 wrap without a separate decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d         <= '0;
      idx       <= '0;
      active    <= 1'b0;
      scan_done <= 1'b0;
      state     <= ST_IDLE;
      dwell_cnt <= '0;
    end else if (!en) begin
      // idx keeps the last active index; a running scan is dropped for good
      d         <= '0;
      active    <= 1'b0;
      scan_done <= 1'b0;
      state     <= ST_IDLE;
      dwell_cnt <= '0;
    end else begin
      scan_done <= 1'b0;
      case (mode)
        MODE_DECODE: begin
          d      <= onehot(sel);
          idx    <= sel;
          active <= 1'b1;
          state  <= ST_DECODE;
        end
        MODE_PULSE: begin
          state <= ST_PULSE;
          if (load) begin
            d      <= onehot(sel);
            idx    <= sel;
            active <= 1'b1;
          end else begin
            d      <= '0;
            active <= 1'b0;
          end
        end
        MODE_SCAN: begin
          if (state == ST_SCAN) begin
            // load and sel are ignored while a scan is running
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end else begin
              dwell_cnt <= DWELL_LAST;
              if (idx == IDX_LAST) begin
                scan_done <= 1'b1;
                if (SCAN_WRAP) begin
                  d   <= {d[OUTS-2:0], d[OUTS-1]};
                  idx <= '0;
                end else begin
                  d      <= '0;
                  active <= 1'b0;
                  state  <= ST_IDLE;
                end
              end else begin
                d   <= {d[OUTS-2:0], d[OUTS-1]};
                idx <= idx + 1'b1;
              end
            end
          end else if (load) begin
            d         <= onehot(sel);
            idx       <= sel;
            active    <= 1'b1;
            dwell_cnt <= DWELL_LAST;
            state     <= ST_SCAN;
          end else begin
            d      <= '0;
            active <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          d      <= '0;
          active <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_nx_seq.sv
// Bench for decoder_nx_seq: two instances share en/mode/load/reset.
//   a: SEL_W=2, DWELL=2, no wrap     b: SEL_W=3, DWELL=1, wrap
// Directed scenarios check hand-derived values; the random phase checks
// both instances against a behavioural model of the decoder rules.
module tb_decoder_nx_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [1:0] sel_a;
  logic [2:0] sel_b;

  logic [3:0] d_a;
  logic [1:0] idx_a;
  logic       active_a;
  logic       done_a;
  logic [7:0] d_b;
  logic [2:0] idx_b;
  logic       active_b;
  logic       done_b;

  int n_checks = 0;
  int n_errors = 0;

  decoder_nx_seq #(.SEL_W(2), .DWELL(2), .SCAN_WRAP(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_a), .load(load),
    .d(d_a), .idx(idx_a), .active(active_a), .scan_done(done_a)
  );

  decoder_nx_seq #(.SEL_W(3), .DWELL(1), .SCAN_WRAP(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_b), .load(load),
    .d(d_b), .idx(idx_b), .active(active_b), .scan_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: "on" says whether an output is lit, idx is which one,
  // shown counts how many cycles the current scan position has been visible.
  typedef struct packed {
    int idx;
    int shown;
    bit on;
    bit run;
    bit done;
  } model_t;

  model_t ma, mb;

  function automatic model_t step(model_t m, int outs, int dwell, bit wrap,
                                  bit r_n, bit e, logic [1:0] md, int s, bit ld);
    model_t n = m;
    n.done = 1'b0;
    if (!r_n) begin
      n = '0;
      return n;
    end
    if (!e) begin
      n.on  = 1'b0;
      n.run = 1'b0;
      return n;
    end
    case (md)
      2'b00: begin n.run = 0; n.on = 1; n.idx = s; end
      2'b01: begin n.run = 0; n.on = ld; if (ld) n.idx = s; end
      2'b10: begin
        if (m.run) begin
          if (m.shown < dwell) n.shown = m.shown + 1;
          else if (m.idx == outs - 1) begin
            n.done = 1;
            if (wrap) begin n.idx = 0; n.shown = 1; end
            else begin n.run = 0; n.on = 0; end
          end else begin
            n.idx = m.idx + 1;
            n.shown = 1;
          end
        end else if (ld) begin
          n.run = 1; n.on = 1; n.idx = s; n.shown = 1;
        end else begin
          n.on = 0;
        end
      end
      default: begin n.run = 0; n.on = 0; end
    endcase
    return n;
  endfunction

  // Advance the model on the same edge the DUTs sample
  always @(posedge clk) begin
    ma <= step(ma, 4, 2, 1'b0, rst_n, en, mode, int'(sel_a), load);
    mb <= step(mb, 8, 1, 1'b1, rst_n, en, mode, int'(sel_b), load);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 2'b00; sel_a = 2'd3; sel_b = 3'd5; load = 1'b0;
    tick(); tick();
    n_checks++;
    if ({d_a, idx_a, active_a, done_a} !== 8'b0) begin
      n_errors++;
      $display("FAIL reset_a d=%b idx=%0d active=%b done=%b required all zero", d_a, idx_a, active_a, done_a);
    end
    n_checks++;
    if ({d_b, idx_b, active_b, done_b} !== 13'b0) begin
      n_errors++;
      $display("FAIL reset_b d=%b idx=%0d active=%b required all zero", d_b, idx_b, active_b);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (d_a !== 4'b1000 || idx_a !== 2'd3 || active_a !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release d=%b idx=%0d active=%b required 1000/3/1", d_a, idx_a, active_a);
    end
  endtask

  task automatic test_decode();
    logic [3:0] exp;
    mode = 2'b00; en = 1'b1; load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      tick();
      exp = 4'b0001 << i;
      n_checks++;
      if (d_a !== exp || idx_a !== 2'(i) || active_a !== 1'b1 || done_a !== 1'b0) begin
        n_errors++;
        $display("FAIL decode_sweep sel=%0d d=%b idx=%0d active=%b required d=%b", i, d_a, idx_a, active_a, exp);
      end
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (d_a !== 4'b0000 || idx_a !== 2'd3 || active_a !== 1'b0) begin
      n_errors++;
      $display("FAIL decode_en_off d=%b idx=%0d active=%b required 0000/3/0", d_a, idx_a, active_a);
    end
  endtask

  task automatic test_pulse();
    en = 1'b1; mode = 2'b01; sel_a = 2'd2; load = 1'b1;
    tick();
    n_checks++;
    if (d_a !== 4'b0100 || active_a !== 1'b1) begin
      n_errors++;
      $display("FAIL pulse_single d=%b active=%b required 0100/1", d_a, active_a);
    end
    load = 1'b0;
    tick();
    n_checks++;
    if (d_a !== 4'b0000 || active_a !== 1'b0 || idx_a !== 2'd2) begin
      n_errors++;
      $display("FAIL pulse_off d=%b active=%b idx=%0d required 0000/0/2", d_a, active_a, idx_a);
    end
    load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (d_a !== 4'b0100) begin
        n_errors++;
        $display("FAIL pulse_held cycle=%0d d=%b required 0100", i, d_a);
      end
    end
    load = 1'b0;
    tick();
    n_checks++;
    if (d_a !== 4'b0000) begin
      n_errors++;
      $display("FAIL pulse_held_end d=%b required 0000", d_a);
    end
  endtask

  task automatic test_scan_nowrap();
    logic [3:0] exp_d [8];
    bit         exp_done [8];
    exp_d    = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    exp_done = '{0, 0, 0, 0, 0, 0, 1, 0};
    en = 1'b1; mode = 2'b11; load = 1'b0;
    tick();
    mode = 2'b10; sel_a = 2'd1; load = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        // a load and new sel mid-scan must be ignored
        load  = (k == 2);
        sel_a = (k == 2) ? 2'd3 : 2'd1;
        tick();
      end
      n_checks++;
      if (d_a !== exp_d[k] || done_a !== exp_done[k] || active_a !== (exp_d[k] != 4'b0)) begin
        n_errors++;
        $display("FAIL scan_nowrap step=%0d d=%b done=%b active=%b required d=%b done=%b",
                 k, d_a, done_a, active_a, exp_d[k], exp_done[k]);
      end
    end
    n_checks++;
    if (idx_a !== 2'd3) begin
      n_errors++;
      $display("FAIL scan_nowrap_idx idx=%0d required 3", idx_a);
    end
  endtask

  task automatic test_scan_wrap();
    logic [7:0] exp_d [4];
    bit         exp_done [4];
    exp_d    = '{8'h40, 8'h80, 8'h01, 8'h02};
    exp_done = '{0, 0, 1, 0};
    en = 1'b1; mode = 2'b11; load = 1'b0;
    tick();
    mode = 2'b10; sel_b = 3'd6; load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      load = 1'b0;
      n_checks++;
      if (d_b !== exp_d[k] || done_b !== exp_done[k]) begin
        n_errors++;
        $display("FAIL scan_wrap step=%0d d=%b done=%b required d=%b done=%b",
                 k, d_b, done_b, exp_d[k], exp_done[k]);
      end
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (d_b !== 8'h00 || done_b !== 1'b0 || active_b !== 1'b0 || idx_b !== 3'd1) begin
      n_errors++;
      $display("FAIL scan_abort_en d=%b done=%b active=%b idx=%0d required 0/0/0/1", d_b, done_b, active_b, idx_b);
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (d_b !== 8'h00 || done_b !== 1'b0) begin
        n_errors++;
        $display("FAIL scan_no_resume cycle=%0d d=%b done=%b required 0/0", k, d_b, done_b);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [3:0] exp_d [3];
    exp_d = '{4'b0001, 4'b0001, 4'b0010};
    en = 1'b1; mode = 2'b10; sel_a = 2'd0; load = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      load = 1'b0;
      n_checks++;
      if (d_a !== exp_d[k] || done_a !== 1'b0) begin
        n_errors++;
        $display("FAIL switch_prescan step=%0d d=%b done=%b required %b/0", k, d_a, done_a, exp_d[k]);
      end
    end
    mode = 2'b00; sel_a = 2'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (d_a !== 4'b0001 || done_a !== 1'b0 || $countones(d_a) > 1) begin
        n_errors++;
        $display("FAIL switch_decode cycle=%0d d=%b done=%b required 0001/0", k, d_a, done_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [4];
    bit         exp_done [4];
    exp_d    = '{4'b1000, 4'b1000, 4'b0000, 4'b1000};
    exp_done = '{0, 0, 1, 0};
    en = 1'b1; mode = 2'b11; load = 1'b0;
    tick();
    mode = 2'b10; sel_a = 2'd3; load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (d_a !== exp_d[k] || done_a !== exp_done[k]) begin
        n_errors++;
        $display("FAIL back_to_back step=%0d d=%b done=%b required %b/%b", k, d_a, done_a, exp_d[k], exp_done[k]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] ea;
    logic [7:0] eb;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      en    = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      load  = ($urandom_range(0, 5) == 0);
      sel_a = 2'($urandom);
      sel_b = 3'($urandom);
      tick();
      ea = '0;
      eb = '0;
      if (ma.on) ea[ma.idx] = 1'b1;
      if (mb.on) eb[mb.idx] = 1'b1;
      n_checks++;
      if (d_a !== ea || idx_a !== 2'(ma.idx) || active_a !== ma.on || done_a !== ma.done) begin
        n_errors++;
        $display("FAIL random_a cycle=%0d d=%b idx=%0d act=%b done=%b required d=%b idx=%0d act=%b done=%b",
                 c, d_a, idx_a, active_a, done_a, ea, ma.idx, ma.on, ma.done);
      end
      n_checks++;
      if (d_b !== eb || idx_b !== 3'(mb.idx) || active_b !== mb.on || done_b !== mb.done) begin
        n_errors++;
        $display("FAIL random_b cycle=%0d d=%b idx=%0d act=%b done=%b required d=%b idx=%0d act=%b done=%b",
                 c, d_b, idx_b, active_b, done_b, eb, mb.idx, mb.on, mb.done);
      end
      n_checks++;
      if ($countones(d_a) > 1 || $countones(d_b) > 1) begin
        n_errors++;
        $display("FAIL random_onehot cycle=%0d d_a=%b d_b=%b required popcount <= 1", c, d_a, d_b);
      end
    end
  endtask

  initial begin
    mode = 2'b00;
    test_reset();
    test_decode();
    test_pulse();
    test_scan_nowrap();
    test_scan_wrap();
    test_mode_switch();
    test_back_to_back();
    mode = 2'b10;
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
